lsu_sequencer: RTL and testbench
================================

Name: lsu_sequencer

Overview:
- Sequences every data-memory access in the MEM stage.
- Inputs are the decoded mem_rd, mem_wr and mem_ctrl from the instruction decoder, plus the ALU-computed address and rs2 store data.
- Drives a single-outstanding req/gnt/rvalid data bus and stalls the pipeline until the access completes.
- Generates byte enables and store-lane alignment; sign- or zero-extends load data for writeback.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles spent in REQ+WAIT before the access is aborted with bus_err; must be >= 1.
- CNT_W, 8: timeout counter width; TIMEOUT_CYCLES must be < 2^CNT_W.

Ports:
- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- mem_valid  input  1  instruction in MEM stage is valid (not a bubble or flush)
- mem_rd  input  1  load request, from decoder
- mem_wr  input  1  store request, from decoder
- mem_ctrl  input  3  access type: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW
- addr  input  32  byte address from ALU
- wdata  input  32  rs2 store data, unaligned (data in low lanes)
- stall  output  1  hold IF/ID/EX/MEM pipeline registers
- ld_data  output  32  extended load result, valid with ld_valid
- ld_valid  output  1  one-cycle pulse: load result ready for writeback
- misalign  output  1  one-cycle pulse: misaligned access detected
- bus_err  output  1  one-cycle pulse: timeout abort
- bus_req  output  1  bus request
- bus_we  output  1  1 = write
- bus_addr  output  32  word-aligned address, {addr[31:2], 2'b00}
- bus_be  output  4  byte enables
- bus_wdata  output  32  lane-aligned store data
- bus_gnt  input  1  bus accepted the request this cycle
- bus_rvalid  input  1  read data valid
- bus_rdata  input  32  read data word

Behaviour:
- Access start: start = mem_valid & (mem_rd | mem_wr) in IDLE. mem_rd & mem_wr both high is treated as a load.
- Reset: state = IDLE, counter = 0. All outputs 0: stall, ld_valid, ld_data, misalign, bus_err, bus_req, bus_we, bus_addr, bus_be, bus_wdata.
- Request capture: on start, the request fields (type, addr, wdata) are registered. The bus outputs come from these registered copies, so the inputs may change while the pipeline is stalled.
- stall (combinational) = (IDLE & start & ~misaligned_now) | REQ | WAIT. stall is 0 in DONE, so the pipeline advances on the DONE cycle.
- Misalignment: halfword with addr[0]=1, or word with addr[1:0]!=0. Handling is per the optional feature.
- Byte enables: byte 0001<<addr[1:0]; half 0011<<{addr[1],1'b0}; word 1111.
- Store data: bus_wdata = wdata << (8*addr[1:0]); word stores are unshifted.
- Load extraction: select the lane by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- FSM:
  - IDLE: on start, go to REQ.
  - REQ: bus_req=1. On bus_gnt, a store goes to DONE; a load goes to WAIT. If bus_rvalid arrives in the same cycle as bus_gnt, a load goes directly to DONE.
  - WAIT: bus_req=0. On bus_rvalid, capture the extended data and go to DONE.
  - DONE: ld_valid=1 for loads only. Return to IDLE.
- Latency: store with immediate gnt is 2 cycles start-to-DONE. Load with gnt and rvalid one cycle apart is 3 cycles.
- Back-to-back accesses: a new start is accepted in the IDLE cycle after DONE. There is no bubble beyond DONE.
- Timeout:
  - The counter resets on entry to REQ and increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES, go to DONE with bus_err=1, ld_valid=0 and ld_data=0.
  - bus_req drops that cycle.
  - Late rvalid or gnt is ignored once IDLE is reached.
- bus_rvalid seen while in IDLE or REQ (before gnt): ignored.
- Reset mid-access: immediate return to IDLE. bus_req drops asynchronously and no ld_valid is produced.
- mem_valid low in IDLE: no access starts, regardless of mem_rd or mem_wr.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned start asserts misalign for 1 cycle in IDLE.
  - No bus access is made, stall stays 0, and the FSM stays in IDLE.
  - ld_valid stays 0. The downstream trap logic consumes misalign.
- Undefined:
  - misalign is tied 0.
  - The offending low address bits are forced to 0: half uses addr[0]=0; word uses addr[1:0]=00.
  - The access proceeds normally as an aligned access.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt on first REQ cycle -> bus_be=1111, bus_wdata=0xDEADBEEF, bus_we=1; stall high 2 cycles; no ld_valid.
- SB addr=0x103, wdata=0x000000A5 -> bus_addr=0x100, bus_be=1000, bus_wdata=0xA5000000.
- LB addr=0x102, bus_rdata=0x12F40000, rvalid 1 cycle after gnt -> ld_valid pulse, ld_data=0xFFFFFFF4. LBU of the same access -> 0x000000F4.
- LH addr=0x102, bus_rdata=0x80010000, gnt held low 3 cycles -> stall high throughout REQ/WAIT, ld_data=0xFFFF8001.
- LW with TIMEOUT_CYCLES=4 and gnt never asserted -> bus_err pulse after 4 REQ cycles, ld_valid=0, FSM in IDLE next cycle.
- LW addr=0x101:
  - LSU_MISALIGN_TRAP_EN defined -> misalign pulse, bus_req never asserted, stall=0.
  - Undefined -> bus_addr=0x100, bus_be=1111, normal completion.

Source files
------------

// File: rtl/lsu_sequencer.sv
// MEM-stage load/store sequencer: single-outstanding req/gnt/rvalid bus, byte lanes, load extension.
// Optional macro LSU_MISALIGN_TRAP_EN: trap misaligned accesses instead of force-aligning them.
module lsu_sequencer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [2:0]  mem_ctrl,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       req_ctrl;
  logic [1:0]       req_off;
  logic             req_load;

  logic        start;
  logic        is_half_in;
  logic        is_word_in;
  logic        misaligned_now;
  logic        trap;
  logic [1:0]  off_eff;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic [31:0] shifted;
  logic [31:0] load_ext;
  logic        timeout_hit;

  assign start      = mem_valid & (mem_rd | mem_wr);
  assign is_half_in = (mem_ctrl == 3'b001) | (mem_ctrl == 3'b100) | (mem_ctrl == 3'b110);
  assign is_word_in = (mem_ctrl == 3'b010) | (mem_ctrl == 3'b111);
  assign misaligned_now = (is_half_in & addr[0]) | (is_word_in & (|addr[1:0]));

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap    = misaligned_now;
  assign off_eff = addr[1:0];
`else
  // Without the trap, misaligned accesses are silently rounded down to their natural alignment.
  assign trap    = 1'b0;
  assign off_eff = is_word_in ? 2'b00 : (is_half_in ? {addr[1], 1'b0} : addr[1:0]);
`endif

  always_comb begin
    be_in = 4'b0001 << off_eff;
    if (is_word_in)      be_in = 4'b1111;
    else if (is_half_in) be_in = 4'b0011 << off_eff;
  end

  assign wdata_in = is_word_in ? wdata : (wdata << {off_eff, 3'b000});

  assign stall = ((state == IDLE) & start & ~trap) | (state == REQ) | (state == WAIT);

  assign shifted = bus_rdata >> {req_off, 3'b000};

  always_comb begin
    load_ext = shifted;
    case (req_ctrl)
      3'b000:          load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:          load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b011, 3'b101:  load_ext = {24'd0, shifted[7:0]};
      3'b100, 3'b110:  load_ext = {16'd0, shifted[15:0]};
      default:         load_ext = shifted;
    endcase
  end

  assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // A completing handshake wins over the timeout on the final budgeted cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ctrl  <= '0;
      req_off   <= '0;
      req_load  <= 1'b0;
      ld_data   <= '0;
      ld_valid  <= 1'b0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
    end else begin
      ld_valid <= 1'b0;
      bus_err  <= 1'b0;
      misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (trap) begin
              misalign <= 1'b1;
            end else begin
              state     <= REQ;
              cnt       <= '0;
              req_ctrl  <= mem_ctrl;
              req_off   <= off_eff;
              req_load  <= mem_rd;
              bus_req   <= 1'b1;
              bus_we    <= ~mem_rd;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_be    <= be_in;
              bus_wdata <= wdata_in;
            end
          end
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (bus_gnt & (~req_load | bus_rvalid)) begin
            state   <= DONE;
            bus_req <= 1'b0;
            if (req_load) begin
              ld_valid <= 1'b1;
              ld_data  <= load_ext;
            end
          end else if (timeout_hit) begin
            state   <= DONE;
            bus_req <= 1'b0;
            bus_err <= 1'b1;
            ld_data <= '0;
          end else if (bus_gnt) begin
            state   <= WAIT;
            bus_req <= 1'b0;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (bus_rvalid) begin
            state    <= DONE;
            ld_valid <= 1'b1;
            ld_data  <= load_ext;
          end else if (timeout_hit) begin
            state   <= DONE;
            bus_err <= 1'b1;
            ld_data <= '0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed testbench for lsu_sequencer (TIMEOUT_CYCLES=4); misalign checks follow LSU_MISALIGN_TRAP_EN.
module tb_lsu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, mem_rd, mem_wr;
  logic [2:0]  mem_ctrl;
  logic [31:0] addr, wdata;
  logic        stall, ld_valid, misalign, bus_err, bus_req, bus_we;
  logic [31:0] ld_data, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvalid;

  int tests = 0;
  int fails = 0;

  lsu_sequencer #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ctrl(mem_ctrl),
    .addr(addr), .wdata(wdata),
    .stall(stall), .ld_data(ld_data), .ld_valid(ld_valid), .misalign(misalign),
    .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic v, input logic rd, input logic wr,
                               input logic [2:0] ctrl, input logic [31:0] a,
                               input logic [31:0] wd);
    mem_valid = v;
    mem_rd    = rd;
    mem_wr    = wr;
    mem_ctrl  = ctrl;
    addr      = a;
    wdata     = wd;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick(); tick();
    checkOutput("rst stall",     32'(stall), 32'd0);
    checkOutput("rst bus_req",   32'(bus_req), 32'd0);
    checkOutput("rst bus_we",    32'(bus_we), 32'd0);
    checkOutput("rst bus_addr",  bus_addr, 32'h0);
    checkOutput("rst bus_be",    32'(bus_be), 32'h0);
    checkOutput("rst bus_wdata", bus_wdata, 32'h0);
    checkOutput("rst ld_data",   ld_data, 32'h0);
    checkOutput("rst pulses",    {29'd0, ld_valid, bus_err, misalign}, 32'd0);
    rst_n = 1'b1;
    tick();

    // mem_valid low: no access even with mem_rd set
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    #1 checkOutput("novalid stall", 32'(stall), 32'd0);
    tick();
    checkOutput("novalid bus_req", 32'(bus_req), 32'd0);

    // SW 0x100, immediate grant
    applyStimulus(1'b1, 1'b0, 1'b1, 3'b111, 32'h100, 32'hDEADBEEF);
    #1 checkOutput("sw stall idle", 32'(stall), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checkOutput("sw bus_req",   32'(bus_req), 32'd1);
    checkOutput("sw bus_we",    32'(bus_we), 32'd1);
    checkOutput("sw bus_addr",  bus_addr, 32'h100);
    checkOutput("sw bus_be",    32'(bus_be), 32'hF);
    checkOutput("sw bus_wdata", bus_wdata, 32'hDEADBEEF);
    checkOutput("sw stall req", 32'(stall), 32'd1);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    checkOutput("sw stall done", 32'(stall), 32'd0);
    checkOutput("sw ld_valid",   32'(ld_valid), 32'd0);
    checkOutput("sw req done",   32'(bus_req), 32'd0);
    tick();

    // SB 0x103
    applyStimulus(1'b1, 1'b0, 1'b1, 3'b101, 32'h103, 32'h000000A5);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'hFFFFFFFF);
    checkOutput("sb bus_addr",  bus_addr, 32'h100);
    checkOutput("sb bus_be",    32'(bus_be), 32'h8);
    checkOutput("sb bus_wdata", bus_wdata, 32'hA5000000);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    tick();

    // SH 0x102
    applyStimulus(1'b1, 1'b0, 1'b1, 3'b110, 32'h102, 32'h00001234);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checkOutput("sh bus_be",    32'(bus_be), 32'hC);
    checkOutput("sh bus_wdata", bus_wdata, 32'h12340000);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    tick();

    // LB 0x102, rvalid one cycle after gnt
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b000, 32'h102, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checkOutput("lb bus_we", 32'(bus_we), 32'd0);
    checkOutput("lb bus_be", 32'(bus_be), 32'h4);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    checkOutput("lb wait req",   32'(bus_req), 32'd0);
    checkOutput("lb wait stall", 32'(stall), 32'd1);
    bus_rvalid = 1'b1; bus_rdata = 32'h12F40000;
    tick();
    bus_rvalid = 1'b0; bus_rdata = 32'h0;
    checkOutput("lb ld_valid", 32'(ld_valid), 32'd1);
    checkOutput("lb ld_data",  ld_data, 32'hFFFFFFF4);
    checkOutput("lb stall",    32'(stall), 32'd0);
    tick();
    checkOutput("lb pulse end", 32'(ld_valid), 32'd0);

    // LBU 0x102 with a stray rvalid before gnt that must be ignored
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b011, 32'h102, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    bus_rvalid = 1'b1; bus_rdata = 32'h11111111;
    tick();
    bus_rvalid = 1'b0;
    checkOutput("lbu still req", 32'(bus_req), 32'd1);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'h12F40000;
    tick();
    bus_rvalid = 1'b0;
    checkOutput("lbu ld_valid", 32'(ld_valid), 32'd1);
    checkOutput("lbu ld_data",  ld_data, 32'h000000F4);
    tick();

    // LH 0x102, gnt low 3 cycles then gnt+rvalid together on the 4th REQ cycle
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b001, 32'h102, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("lh stall req", 32'(stall), 32'd1);
      tick();
    end
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h80010000;
    tick();
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    checkOutput("lh ld_valid", 32'(ld_valid), 32'd1);
    checkOutput("lh ld_data",  ld_data, 32'hFFFF8001);
    checkOutput("lh bus_err",  32'(bus_err), 32'd0);
    tick();

    // LW timeout after 4 REQ cycles
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h200, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick(); tick(); tick();
    checkOutput("to req 4th", 32'(bus_req), 32'd1);
    tick();
    checkOutput("to bus_err",  32'(bus_err), 32'd1);
    checkOutput("to ld_valid", 32'(ld_valid), 32'd0);
    checkOutput("to ld_data",  ld_data, 32'h0);
    checkOutput("to bus_req",  32'(bus_req), 32'd0);
    checkOutput("to stall",    32'(stall), 32'd0);
    bus_gnt = 1'b1; bus_rvalid = 1'b1;
    tick();
    checkOutput("to err end", 32'(bus_err), 32'd0);
    tick();
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    checkOutput("late ignored req",   32'(bus_req), 32'd0);
    checkOutput("late ignored valid", 32'(ld_valid), 32'd0);

    // LW 0x101 misaligned
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h101, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    #1 checkOutput("mis stall", 32'(stall), 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checkOutput("mis pulse",   32'(misalign), 32'd1);
    checkOutput("mis bus_req", 32'(bus_req), 32'd0);
    tick();
    checkOutput("mis pulse end", 32'(misalign), 32'd0);
    checkOutput("mis no req",    32'(bus_req), 32'd0);
`else
    #1 checkOutput("mis stall", 32'(stall), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checkOutput("mis bus_addr", bus_addr, 32'h100);
    checkOutput("mis bus_be",   32'(bus_be), 32'hF);
    checkOutput("mis misalign", 32'(misalign), 32'd0);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
    tick();
    bus_rvalid = 1'b0;
    checkOutput("mis ld_valid", 32'(ld_valid), 32'd1);
    checkOutput("mis ld_data",  ld_data, 32'hCAFEF00D);
    tick();
`endif

    // Reset in the middle of an access drops bus_req immediately
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checkOutput("mid req", 32'(bus_req), 32'd1);
    rst_n = 1'b0;
    #1 checkOutput("mid rst req", 32'(bus_req), 32'd0);
    checkOutput("mid rst stall", 32'(stall), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("mid rst ld_valid", 32'(ld_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
